// File: rtl/bullet_pkg.sv
// Shared widths, FSM encoding and slot-table field helpers for the bullet scheduler.
package bullet_pkg;

    localparam int X_W = 12;
    localparam int Y_W = 11;

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } state_t;

    // LSB of slot `slot` inside a packed table whose fields are `width` bits wide
    function automatic int field_lsb(input int slot, input int width);
        return slot * width;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/free_slot_finder.sv
// Combinational lowest-index-free-slot priority encoder over the slot valid bits.
module free_slot_finder
    import bullet_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    localparam int IDX_W = idx_w(NUM_SLOTS)
) (
    input  logic [NUM_SLOTS-1:0] slot_valid,
    output logic                 found,
    output logic [IDX_W-1:0]     index
);

    // Scan from the top so the lowest free slot is the last one written
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_valid[i]) begin
                found = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bullet_scheduler.sv
// Bullet slot pool: fire-edge spawning with frame cooldown, and a once-per-frame
// motion walk that touches one slot per cycle.
module bullet_scheduler #(
    parameter int NUM_SLOTS = 8,
    parameter int SPEED     = 8,
    parameter int COOLDOWN  = 4,
    parameter int X_OFFSET  = 28,
    parameter int X_W       = bullet_pkg::X_W,
    parameter int Y_W       = bullet_pkg::Y_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     fire,
    input  logic [X_W-1:0]           ship_x,
    input  logic [Y_W-1:0]           ship_y,
    input  logic                     calc,
    output logic [NUM_SLOTS-1:0]     slot_valid,
    output logic [NUM_SLOTS*X_W-1:0] slot_x,
    output logic [NUM_SLOTS*Y_W-1:0] slot_y,
    output logic                     busy,
    output logic                     fire_ack,
    output logic                     fire_drop
);
    import bullet_pkg::*;

    localparam int IDX_W = idx_w(NUM_SLOTS);
    localparam int CD_W  = idx_w(COOLDOWN + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

    state_t           state, state_next;
    logic [IDX_W-1:0] idx;
    logic [CD_W-1:0]  cooldown;
    logic             pending;
    logic             fire_q;
    logic             fire_rise;
    logic             do_alloc, do_drop, do_step;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic [X_W-1:0]   xs [NUM_SLOTS];
    logic [Y_W-1:0]   ys [NUM_SLOTS];

    free_slot_finder #(.NUM_SLOTS(NUM_SLOTS)) finder (
        .slot_valid (slot_valid),
        .found      (free_found),
        .index      (free_idx)
    );

    assign fire_rise = fire & ~fire_q;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
        assign slot_x[field_lsb(g, X_W) +: X_W] = xs[g];
        assign slot_y[field_lsb(g, Y_W) +: Y_W] = ys[g];
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // calc wins over a pending spawn; the spawn is retried once the walk ends
    always_comb begin
        state_next = state;
        do_alloc   = 1'b0;
        do_drop    = 1'b0;
        do_step    = 1'b0;
        case (state)
            IDLE: begin
                if (calc) begin
                    state_next = UPDATE;
                end else if (pending) begin
                    do_alloc = free_found;
                    do_drop  = ~free_found;
                end
            end
            UPDATE: begin
                do_step = 1'b1;
                if (idx == LAST_IDX) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // fire_q keeps tracking the button through reset so a button held across
    // reset does not fire on release
    always_ff @(posedge clock) begin
        fire_q <= fire;
        if (reset) begin
            idx        <= '0;
            cooldown   <= '0;
            pending    <= 1'b0;
            busy       <= 1'b0;
            fire_ack   <= 1'b0;
            fire_drop  <= 1'b0;
            slot_valid <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
            end
        end else begin
            busy      <= (state_next == UPDATE);
            fire_ack  <= do_alloc;
            fire_drop <= do_drop;
            idx       <= (state == UPDATE && idx != LAST_IDX) ? idx + 1'b1 : '0;

            if (do_alloc)
                cooldown <= CD_W'(COOLDOWN);
            else if (calc && cooldown != '0)
                cooldown <= cooldown - 1'b1;

            if (do_alloc || do_drop)
                pending <= 1'b0;
            else if (fire_rise && cooldown == '0 && !pending)
                pending <= 1'b1;

            if (do_alloc) begin
                slot_valid[free_idx] <= 1'b1;
                xs[free_idx]         <= ship_x + X_W'(X_OFFSET);
                ys[free_idx]         <= ship_y;
            end

            if (do_step && slot_valid[idx]) begin
                if (ys[idx] < Y_W'(SPEED))
                    slot_valid[idx] <= 1'b0;
                else
                    ys[idx] <= ys[idx] - Y_W'(SPEED);
            end
        end
    end

endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed bench for bullet_scheduler with a slot-table model checked every cycle.
module tb_bullet_scheduler;
    localparam int NS = 4, SPEED = 8, CD = 2, XO = 28, XW = 12, YW = 11;

    logic clock = 1'b0;
    logic reset, fire, calc;
    logic [XW-1:0] ship_x;
    logic [YW-1:0] ship_y;
    logic [NS-1:0] slot_valid;
    logic [NS*XW-1:0] slot_x;
    logic [NS*YW-1:0] slot_y;
    logic busy, fire_ack, fire_drop;

    always #5 clock = ~clock;

    bullet_scheduler #(
        .NUM_SLOTS(NS), .SPEED(SPEED), .COOLDOWN(CD), .X_OFFSET(XO), .X_W(XW), .Y_W(YW)
    ) dut (
        .clock(clock), .reset(reset), .fire(fire), .ship_x(ship_x), .ship_y(ship_y),
        .calc(calc), .slot_valid(slot_valid), .slot_x(slot_x), .slot_y(slot_y),
        .busy(busy), .fire_ack(fire_ack), .fire_drop(fire_drop)
    );

    int total = 0, bad = 0;
    int ack_cnt = 0, drop_cnt = 0, busy_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: the pool as plain arrays, the frame walk as a count of slots still to visit
    bit mv [NS];
    int mx [NS];
    int my [NS];
    bit m_pend = 0, m_fq = 0, m_ack = 0, m_drop = 0, started = 0;
    int m_cd = 0, m_walk = 0;

    always @(posedge clock) begin
        bit rise, old_pend;
        int old_cd, s, f;
        started = 1;
        rise = fire && !m_fq;
        m_fq = fire;
        if (reset) begin
            for (int i = 0; i < NS; i++) begin mv[i] = 0; mx[i] = 0; my[i] = 0; end
            m_pend = 0; m_cd = 0; m_walk = 0; m_ack = 0; m_drop = 0;
        end else begin
            old_cd = m_cd; old_pend = m_pend;
            m_ack = 0; m_drop = 0;
            if (calc && old_cd > 0) m_cd = old_cd - 1;
            if (rise && old_cd == 0 && !old_pend) m_pend = 1;
            if (m_walk > 0) begin
                s = NS - m_walk;
                if (mv[s]) begin
                    if (my[s] < SPEED) mv[s] = 0;
                    else my[s] = my[s] - SPEED;
                end
                m_walk--;
            end else if (calc) begin
                m_walk = NS;
            end else if (old_pend) begin
                f = -1;
                for (int i = NS - 1; i >= 0; i--) if (!mv[i]) f = i;
                if (f >= 0) begin
                    mv[f] = 1; mx[f] = (int'(ship_x) + XO) % 4096; my[f] = int'(ship_y);
                    m_cd = CD; m_ack = 1;
                end else begin
                    m_drop = 1;
                end
                m_pend = 0;
            end
        end
    end

    always @(negedge clock) begin
        logic [NS-1:0] ev;
        logic [NS*XW-1:0] ex;
        logic [NS*YW-1:0] ey;
        if (started) begin
            for (int i = 0; i < NS; i++) begin
                ev[i] = mv[i];
                ex[i*XW +: XW] = XW'(mx[i]);
                ey[i*YW +: YW] = YW'(my[i]);
            end
            chk("slot_valid", 64'(slot_valid), 64'(ev));
            chk("slot_x", 64'(slot_x), 64'(ex));
            chk("slot_y", 64'(slot_y), 64'(ey));
            chk("busy", 64'(busy), 64'(m_walk > 0));
            chk("fire_ack", 64'(fire_ack), 64'(m_ack));
            chk("fire_drop", 64'(fire_drop), 64'(m_drop));
            if (fire_ack) ack_cnt++;
            if (fire_drop) drop_cnt++;
            if (busy) busy_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_fire();
        fire = 0; tick(1);
        fire = 1; tick(4);
    endtask

    task automatic do_calc();
        calc = 1; tick(1);
        calc = 0; tick(6);
    endtask

    initial begin
        int b0;
        reset = 1; fire = 1; calc = 0; ship_x = '0; ship_y = '0;
        // reset with fire held and calc pulsing
        @(negedge clock); calc = 1;
        @(negedge clock); calc = 0;
        @(negedge clock); calc = 1;
        @(negedge clock); calc = 0; reset = 0;
        chk("rst_valid", 64'(slot_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        tick(5);
        chk("held_no_spawn", 64'(ack_cnt), 64'd0);

        // first spawn, exact latency
        ship_x = 12'd100; ship_y = 11'd500;
        fire = 0; tick(1);
        fire = 1; tick(1);
        chk("ack_not_yet", 64'(fire_ack), 64'd0);
        tick(1);
        chk("ack_pulse", 64'(fire_ack), 64'd1);
        chk("spawn_valid", 64'(slot_valid), 64'h1);
        chk("spawn_x0", 64'(slot_x[11:0]), 64'd128);
        chk("spawn_y0", 64'(slot_y[10:0]), 64'd500);
        tick(50);
        chk("held_one_ack", 64'(ack_cnt), 64'd1);

        // frame walk
        b0 = busy_cnt;
        do_calc();
        chk("walk_len", 64'(busy_cnt - b0), 64'd4);
        chk("walk_y0", 64'(slot_y[10:0]), 64'd492);

        // cooldown = 1: edge discarded, not latched
        do_fire();
        chk("cd_no_ack", 64'(ack_cnt), 64'd1);
        do_calc();
        chk("cd_no_late_spawn", 64'(ack_cnt), 64'd1);
        do_fire();
        chk("second_ack", 64'(ack_cnt), 64'd2);
        chk("second_valid", 64'(slot_valid), 64'h3);
        chk("second_y1", 64'(slot_y[21:11]), 64'd500);

        // calc reissued mid-walk is ignored
        do_calc(); do_calc();
        b0 = busy_cnt;
        calc = 1; tick(1); calc = 0; tick(1);
        calc = 1; tick(1); calc = 0; tick(6);
        chk("midwalk_len", 64'(busy_cnt - b0), 64'd4);
        chk("midwalk_y0", 64'(slot_y[10:0]), 64'd460);

        // fill the pool then overflow
        do_fire(); do_calc(); do_calc();
        do_fire(); do_calc(); do_calc();
        chk("pool_full", 64'(slot_valid), 64'hF);
        do_fire();
        chk("drop_seen", 64'(drop_cnt), 64'd1);
        chk("drop_no_ack", 64'(ack_cnt), 64'd4);
        chk("drop_table", 64'(slot_valid), 64'hF);

        // edge and calc together: walk first, drop after busy falls
        fire = 0; tick(1);
        fire = 1; calc = 1; tick(1);
        calc = 0;
        chk("both_busy", 64'(busy), 64'd1);
        tick(4);
        chk("both_busy_fell", 64'(busy), 64'd0);
        chk("both_no_drop_yet", 64'(drop_cnt), 64'd1);
        tick(1);
        chk("both_drop", 64'(fire_drop), 64'd1);

        // boundary: y reaching exactly 0, y below SPEED, x wrap
        reset = 1; tick(2); reset = 0; fire = 0;
        ship_x = 12'd4090; ship_y = 11'd16;
        do_fire();
        chk("wrap_x", 64'(slot_x[11:0]), 64'd22);
        do_calc(); do_calc();
        chk("y0_valid", 64'(slot_valid), 64'h1);
        chk("y0_value", 64'(slot_y[10:0]), 64'd0);
        do_calc();
        chk("y0_cleared", 64'(slot_valid), 64'h0);
        ship_y = 11'd5;
        do_fire();
        chk("y5_valid", 64'(slot_valid), 64'h1);
        do_calc();
        chk("y5_cleared", 64'(slot_valid), 64'h0);
        do_calc();

        // reset in the middle of a walk
        ship_y = 11'd100;
        do_fire();
        chk("pre_rst_valid", 64'(slot_valid), 64'h1);
        calc = 1; tick(1); calc = 0; tick(1);
        reset = 1; tick(1);
        chk("midrst_valid", 64'(slot_valid), 64'h0);
        chk("midrst_busy", 64'(busy), 64'd0);
        reset = 0; tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
